piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter; the sending end of the serial-to-parallel encoder link.
//  Accepts a WIDTH-bit word via valid/ready handshake, shifts it out one bit per bit period on
//  serial_out, and drives the TB bit strobe that the receiving SIPO uses as its shift enable.
//  Pulses done once the last bit has been sent. Sits between a parallel data source and the serial wire.
// PARAMETERS
//  WIDTH         32  word length in bits (>=2); must match the receiving SIPO WIDTH
//  CLKS_PER_BIT   1  clk cycles each bit is held on serial_out (>=1)
//  MSB_FIRST      1  1: send D[WIDTH-1] first (matches the left-shifting SIPO); 0: send D[0] first
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  D           in   WIDTH  parallel word, sampled only on handshake
//  valid       in   1      source has a word on D
//  ready       out  1      block is idle and accepts a word this cycle
//  serial_out  out  1      serial data bit
//  TB          out  1      bit strobe: high exactly one clk per bit, on the first cycle of its period
//  done        out  1      one-cycle pulse after the final bit period
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, shift reg=0, bit cnt=0, period cnt=0; ready=1,
//   serial_out=0, TB=0, done=0. Reset mid-frame aborts the frame: no done pulse, the word is lost.
//  All outputs are registered. Counters: bit cnt $clog2(WIDTH+1) bits, period cnt max($clog2(CLKS_PER_BIT),1) bits.
//  States:
//   IDLE : ready=1, TB=0, serial_out=0. On valid&&ready at edge N: latch D, bit cnt=0,
//          period cnt=0, go SHIFT. First bit is visible on serial_out with TB=1 in the cycle after edge N.
//   SHIFT: serial_out = current head bit (MSB or LSB per MSB_FIRST). TB=1 only when period cnt==0.
//          Period cnt counts 0..CLKS_PER_BIT-1, then wraps to 0. On wrap, the shift reg shifts
//          toward the head and bit cnt increments. After bit WIDTH-1 completes its period, go DONE.
//   DONE : one cycle; done=1, TB=0, serial_out=0, ready=0; next state is IDLE.
//  A frame occupies WIDTH*CLKS_PER_BIT cycles in SHIFT. Handshake to handshake is at least
//   WIDTH*CLKS_PER_BIT+2 cycles (SHIFT, then DONE, then IDLE).
//  ready=0 in SHIFT and DONE. While ready=0, valid is ignored and D is don't-care. D changing
//   after handshake does not affect the frame in flight.
//  With CLKS_PER_BIT=1, TB stays high for exactly WIDTH consecutive cycles, so the receiving SIPO
//   captures the full word with the first-sent bit in Q[WIDTH-1].
//  valid held high continuously: a new word is accepted at each IDLE cycle; no word is duplicated or dropped.
// TESTING
//  1 WIDTH=8,CPB=1,D=8'hA5 handshake -> serial_out 1,0,1,0,0,1,0,1 with TB=1 for 8 cycles; done on cycle 9; ready on cycle 10.
//  2 Loopback into SIPO (WIDTH=32): send 32'hDEADBEEF then 32'h12345678 back-to-back -> receiver Q equals each word after its frame.
//  3 WIDTH=8,CPB=3,D=8'hC3 -> each bit held 3 cycles, TB high on cycles 0,3,...,21 only; done at cycle 24.
//  4 WIDTH=8,D=8'h01: MSB_FIRST=1 -> serial_out 0000_0001; MSB_FIRST=0 -> serial_out 1000_0000.
//  5 Drive reset=0 after bit 3 of 8'hFF -> serial_out, TB and done go 0 immediately; ready=1; after release, no done pulse and the next word is sent cleanly.
//  6 Assert valid with D=8'h55 mid-frame of 8'hAA -> ignored; 8'hAA is sent intact; 8'h55 is accepted only at the next IDLE.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out one bit
// per bit period (CLKS_PER_BIT clocks) on serial_out. TB pulses on the first clock
// of every bit period and acts as the shift enable of the receiving SIPO. done
// pulses for one clock after the final bit period.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous reset, active low
//   D           in   parallel word, sampled only on valid && ready
//   valid       in   source presents a word on D
//   ready       out  idle, a word is accepted this cycle
//   serial_out  out  serial data bit
//   TB          out  bit strobe, high on the first clock of each bit period
//   done        out  one-cycle pulse after the last bit period
//
// All outputs are registered.
module piso_serializer #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    input  logic             valid,
    output logic             ready,
    output logic             serial_out,
    output logic             TB,
    output logic             done
);

    localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned PER_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);
    localparam logic [PER_CNT_W-1:0] LAST_PER = PER_CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state,      state_n;
    logic [WIDTH-1:0]     shreg,      shreg_n;
    logic [BIT_CNT_W-1:0] bit_cnt,    bit_cnt_n;
    logic [PER_CNT_W-1:0] per_cnt,    per_cnt_n;
    logic                 ready_n;
    logic                 serial_n;
    logic                 tb_n;
    logic                 done_n;

    // Shift register advanced one position toward the transmitted head bit.
    logic [WIDTH-1:0] shreg_adv_c;
    always_comb begin
        if (MSB_FIRST) begin
            shreg_adv_c = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            shreg_adv_c = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            per_cnt    <= '0;
            ready      <= 1'b1;
            serial_out <= 1'b0;
            TB         <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_cnt_n;
            per_cnt    <= per_cnt_n;
            ready      <= ready_n;
            serial_out <= serial_n;
            TB         <= tb_n;
            done       <= done_n;
        end
    end

    // Next state, datapath and next registered outputs.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        per_cnt_n = per_cnt;
        ready_n   = 1'b0;
        serial_n  = 1'b0;
        tb_n      = 1'b0;
        done_n    = 1'b0;

        case (state)
            S_IDLE: begin
                if (valid && ready) begin
                    shreg_n   = D;
                    bit_cnt_n = '0;
                    per_cnt_n = '0;
                    state_n   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // End of a bit period: present the next bit, or finish after the last one.
                if (per_cnt == LAST_PER) begin
                    per_cnt_n = '0;
                    shreg_n   = shreg_adv_c;
                    bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state_n = S_DONE;
                    end
                end else begin
                    per_cnt_n = per_cnt + PER_CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it after the edge.
        ready_n = (state_n == S_IDLE);
        done_n  = (state_n == S_DONE);
        if (state_n == S_SHIFT) begin
            tb_n     = (per_cnt_n == '0);
            serial_n = MSB_FIRST ? shreg_n[WIDTH-1] : shreg_n[0];
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for piso_serializer.
// Four instances cover 8-bit MSB-first, 8-bit with 3 clocks per bit, 8-bit
// LSB-first and a 32-bit link. Words are queued when handshaken; a monitor acting
// as the receiving SIPO rebuilds each frame from TB/serial_out and compares it
// with the queue head when done pulses, also checking strobe phase, bit hold,
// frame length, and the ready/done sequencing around the frame.
module tb_piso_serializer;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        valid_drv = 1'b0;
    logic [31:0] d_drv     = '0;
    logic [1:0]  sel       = 2'd0;

    logic [3:0] ready_a;
    logic [3:0] ser_a;
    logic [3:0] tb_a;
    logic [3:0] done_a;

    logic s_ready, s_ser, s_tb, s_done;
    assign s_ready = ready_a[sel];
    assign s_ser   = ser_a[sel];
    assign s_tb    = tb_a[sel];
    assign s_done  = done_a[sel];

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    int          sent      = 0;
    int          frames_rx = 0;
    int          cycle     = 0;
    int          last_hs   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk(clk), .reset(reset), .D(d_drv[7:0]), .valid(valid_drv && (sel == 2'd0)),
        .ready(ready_a[0]), .serial_out(ser_a[0]), .TB(tb_a[0]), .done(done_a[0]));

    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(3), .MSB_FIRST(1'b1)) u_dut_cpb3 (
        .clk(clk), .reset(reset), .D(d_drv[7:0]), .valid(valid_drv && (sel == 2'd1)),
        .ready(ready_a[1]), .serial_out(ser_a[1]), .TB(tb_a[1]), .done(done_a[1]));

    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk(clk), .reset(reset), .D(d_drv[7:0]), .valid(valid_drv && (sel == 2'd2)),
        .ready(ready_a[2]), .serial_out(ser_a[2]), .TB(tb_a[2]), .done(done_a[2]));

    piso_serializer #(.WIDTH(32), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_dut_w32 (
        .clk(clk), .reset(reset), .D(d_drv), .valid(valid_drv && (sel == 2'd3)),
        .ready(ready_a[3]), .serial_out(ser_a[3]), .TB(tb_a[3]), .done(done_a[3]));

    function automatic int w_of(input logic [1:0] k);
        return (k == 2'd3) ? 32 : 8;
    endfunction

    function automatic int cpb_of(input logic [1:0] k);
        return (k == 2'd1) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input logic [1:0] k);
        return (k != 2'd2);
    endfunction

    function automatic logic [31:0] mask_of(input logic [1:0] k);
        return (w_of(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << w_of(k)) - 32'd1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    // Receiving-side model: rebuilds each frame and checks it against the scoreboard.
    bit          in_frame  = 1'b0;
    bit          post_done = 1'b0;
    int          cyc_f     = 0;
    int          nbits     = 0;
    logic [31:0] rx        = '0;
    logic [31:0] exp_w;
    logic        hold_bit  = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            in_frame  = 1'b0;
            post_done = 1'b0;
        end else begin
            if (post_done) begin
                check_eq("ready_after_done", 32'(s_ready), 32'd1);
                check_eq("done_one_cycle", 32'(s_done), 32'd0);
                post_done = 1'b0;
            end else if (!in_frame && !s_tb) begin
                check_eq("done_while_idle", 32'(s_done), 32'd0);
            end
            if (!in_frame && s_tb) begin
                in_frame = 1'b1;
                cyc_f    = 0;
                nbits    = 0;
                rx       = '0;
            end
            if (in_frame) begin
                if (s_done) begin
                    check_eq("frame_len", 32'(cyc_f), 32'(w_of(sel) * cpb_of(sel)));
                    check_eq("tb_count", 32'(nbits), 32'(w_of(sel)));
                    check_eq("tb_in_done", 32'(s_tb), 32'd0);
                    check_eq("ser_in_done", 32'(s_ser), 32'd0);
                    if (exp_q.size() == 0) begin
                        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check_eq("word", rx, exp_w);
                    end
                    frames_rx++;
                    in_frame  = 1'b0;
                    post_done = 1'b1;
                end else begin
                    check_eq("ready_busy", 32'(s_ready), 32'd0);
                    check_eq("tb_phase", 32'(s_tb), 32'((cyc_f % cpb_of(sel)) == 0));
                    if (s_tb) begin
                        hold_bit = s_ser;
                        if (msb_of(sel)) rx = (rx << 1) | 32'(s_ser);
                        else             rx = rx | (32'(s_ser) << nbits);
                        nbits++;
                    end else begin
                        check_eq("bit_hold", 32'(s_ser), 32'(hold_bit));
                    end
                    cyc_f++;
                    if (cyc_f > w_of(sel) * cpb_of(sel) + 2) begin
                        check_eq("frame_timeout", 32'(cyc_f), 32'(w_of(sel) * cpb_of(sel)));
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic select(input logic [1:0] k);
        @(posedge clk);
        #2;
        sel = k;
    endtask

    task automatic send(input logic [31:0] w, input bit hold, input bit chk_gap);
        int n = 0;
        @(negedge clk);
        d_drv     = w;
        valid_drv = 1'b1;
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check_eq("hs_timeout", 32'(s_ready), 32'd1);
            valid_drv = 1'b0;
            return;
        end
        exp_q.push_back(w & mask_of(sel));
        sent++;
        @(posedge clk);
        #1;
        if (chk_gap) check_eq("hs_gap", 32'(cycle - last_hs), 32'(w_of(sel) * cpb_of(sel) + 2));
        last_hs = cycle;
        check_eq("hs_ready_low", 32'(s_ready), 32'd0);
        check_eq("hs_first_tb", 32'(s_tb), 32'd1);
        if (!hold) valid_drv = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_frame || post_done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            check_eq("rst_ready", 32'(s_ready), 32'd1);
            check_eq("rst_serial", 32'(s_ser), 32'd0);
            check_eq("rst_tb", 32'(s_tb), 32'd0);
            check_eq("rst_done", 32'(s_done), 32'd0);
        end
        sel = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic MSB-first frame.
        send(32'h0000_00A5, 1'b0, 1'b0);
        drain();

        // valid/D presented mid-frame are ignored until the next idle cycle.
        send(32'h0000_00AA, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        send(32'h0000_0055, 1'b0, 1'b0);
        drain();

        for (int i = 0; i < 3; i++) begin
            send($urandom, 1'b0, 1'b0);
            drain();
        end

        // Asynchronous reset in the middle of a frame.
        send(32'h0000_00FF, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_serial", 32'(s_ser), 32'd0);
        check_eq("abort_tb", 32'(s_tb), 32'd0);
        check_eq("abort_done", 32'(s_done), 32'd0);
        check_eq("abort_ready", 32'(s_ready), 32'd1);
        void'(exp_q.pop_back());
        sent--;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        send(32'h0000_00A5, 1'b0, 1'b0);
        drain();

        // Three clocks per bit.
        select(2'd1);
        send(32'h0000_00C3, 1'b0, 1'b0);
        drain();
        send($urandom, 1'b0, 1'b0);
        drain();

        // Bit order: same word through MSB-first and LSB-first instances.
        select(2'd0);
        send(32'h0000_0001, 1'b0, 1'b0);
        drain();
        select(2'd2);
        send(32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'h0000_00B4, 1'b0, 1'b0);
        drain();

        // 32-bit words back to back into the receiver model.
        select(2'd3);
        send(32'hDEAD_BEEF, 1'b1, 1'b0);
        send(32'h1234_5678, 1'b0, 1'b1);
        drain();

        // valid held high across several words: one accept per idle cycle.
        select(2'd0);
        send(32'h0000_003C, 1'b1, 1'b0);
        send(32'h0000_0081, 1'b1, 1'b1);
        send(32'h0000_007E, 1'b0, 1'b1);
        drain();

        check_eq("frames_total", 32'(frames_rx), 32'(sent));
        check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
